// File: rtl/counter_input_ctrl.sv
// -----------------------------------------------------------------------------
// counter_input_ctrl
//
// Input-side front end for the 4-bit counter datapath. Conditions the raw
// board pushbuttons and switches (2-flop synchronizer, debouncer, press-edge
// detector) and produces the data bus, a stretched load enable and the
// up/down direction consumed by the counter. Load is held long enough to be
// sampled by a counter running on the divided (slow) clock. Everything runs
// in the fast board-clock domain.
//
// Ports:
//   clk       in   1  board clock, rising edge
//   rst       in   1  asynchronous active-low reset (0 = reset)
//   btn_load  in   1  raw load pushbutton (asynchronous)
//   btn_dir   in   1  raw direction pushbutton (asynchronous)
//   sw_data   in   4  raw data switches (asynchronous)
//   data_out  out  4  captured load value -> counter data_in
//   load      out  1  stretched load enable -> counter load
//   up_down   out  1  count direction (1 = up, 0 = down) -> counter up_down
//
// Parameters:
//   DEBOUNCE_CYCLES  stable clk cycles needed to accept a new button level
//   HOLD_CYCLES      clk cycles load stays high after a capture
//   BTN_ACTIVE_LOW   1 = raw buttons read 0 when pressed
//
// Build option:
//   COUNTER_INPUT_DIR_TOGGLE_EN  defined: each btn_dir press toggles up_down.
//                                undefined: up_down = NOT debounced btn_dir.
// -----------------------------------------------------------------------------
module counter_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES     = 50_000_000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_load,
  input  logic       btn_dir,
  input  logic [3:0] sw_data,
  output logic [3:0] data_out,
  output logic       load,
  output logic       up_down
);

  // Guard against a zero-width counter when a cycle count of 1 is chosen.
  localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0]   DB_ONE   = DB_W'(1'b1);
  localparam logic [DB_W-1:0]   DB_ZERO  = DB_W'(1'b0);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1'b1);
  localparam logic [HOLD_W-1:0] HOLD_ZERO = HOLD_W'(1'b0);

  typedef enum logic [0:0] {
    L_IDLE = 1'b0,
    L_HOLD = 1'b1
  } load_state_t;

  // Synchronizer bit layout: [5:2] sw_data, [1] btn_dir, [0] btn_load.
  logic [5:0]      sync1_r;
  logic [5:0]      sync2_r;
  logic [1:0]      btn_s;          // [1] dir, [0] load; 1 = pressed
  logic [3:0]      sw_sync_s;

  logic [1:0]      stable_r;       // debounced button states, 1 = pressed
  logic [DB_W-1:0] db_cnt_r [2];
  logic            load_stable_d_r;
  logic            load_press_s;

  load_state_t       state_r;
  load_state_t       state_s;
  logic [HOLD_W-1:0] hold_cnt_r;
  logic [HOLD_W-1:0] hold_cnt_s;
  logic              load_r;
  logic              load_s;
  logic [3:0]        data_r;
  logic [3:0]        data_s;

  // Two-flop synchronizer for every raw pin.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r <= 6'b00_0000;
      sync2_r <= 6'b00_0000;
    end else begin
      sync1_r <= {sw_data, btn_dir, btn_load};
      sync2_r <= sync1_r;
    end
  end

  // Normalize buttons so that 1 always means pressed.
  assign btn_s     = BTN_ACTIVE_LOW ? ~sync2_r[1:0] : sync2_r[1:0];
  assign sw_sync_s = sync2_r[5:2];

  // Debouncers: a level is accepted only after DEBOUNCE_CYCLES consecutive
  // cycles of disagreement with the current stable state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable_r    <= 2'b00;
      db_cnt_r[0] <= DB_ZERO;
      db_cnt_r[1] <= DB_ZERO;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (btn_s[i] == stable_r[i]) begin
          db_cnt_r[i] <= DB_ZERO;
        end else if (db_cnt_r[i] == DB_MAX) begin
          stable_r[i] <= btn_s[i];
          db_cnt_r[i] <= DB_ZERO;
        end else begin
          db_cnt_r[i] <= db_cnt_r[i] + DB_ONE;
        end
      end
    end
  end

  // Delayed copy of the debounced load button for rising-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_stable_d_r <= 1'b0;
    end else begin
      load_stable_d_r <= stable_r[0];
    end
  end

  assign load_press_s = stable_r[0] & ~load_stable_d_r;

  // Load FSM next-state and output logic.
  always_comb begin
    state_s    = state_r;
    hold_cnt_s = hold_cnt_r;
    load_s     = load_r;
    data_s     = data_r;
    case (state_r)
      L_IDLE: begin
        if (load_press_s) begin
          data_s     = sw_sync_s;
          load_s     = 1'b1;
          hold_cnt_s = HOLD_ZERO;
          state_s    = L_HOLD;
        end else begin
          load_s = 1'b0;
        end
      end
      L_HOLD: begin
        // Presses here are deliberately ignored: no restart, no recapture.
        if (hold_cnt_r == HOLD_MAX) begin
          load_s     = 1'b0;
          hold_cnt_s = HOLD_ZERO;
          state_s    = L_IDLE;
        end else begin
          hold_cnt_s = hold_cnt_r + HOLD_ONE;
        end
      end
      default: begin
        load_s     = 1'b0;
        hold_cnt_s = HOLD_ZERO;
        state_s    = L_IDLE;
      end
    endcase
  end

  // Load FSM state and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= L_IDLE;
      hold_cnt_r <= HOLD_ZERO;
      load_r     <= 1'b0;
      data_r     <= 4'h0;
    end else begin
      state_r    <= state_s;
      hold_cnt_r <= hold_cnt_s;
      load_r     <= load_s;
      data_r     <= data_s;
    end
  end

  assign load     = load_r;
  assign data_out = data_r;

`ifdef COUNTER_INPUT_DIR_TOGGLE_EN
  logic dir_stable_d_r;
  logic up_down_r;

  // Toggle direction once per debounced press; holding gives one toggle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dir_stable_d_r <= 1'b0;
      up_down_r      <= 1'b1;
    end else begin
      dir_stable_d_r <= stable_r[1];
      if (stable_r[1] && !dir_stable_d_r) begin
        up_down_r <= ~up_down_r;
      end else begin
        up_down_r <= up_down_r;
      end
    end
  end

  assign up_down = up_down_r;
`else
  // Direction follows the debounced level: released = up, held = down.
  assign up_down = ~stable_r[1];
`endif

endmodule

// File: doc/counter_input_ctrl.md
Name: counter_input_ctrl

Overview:
- Input-side front end for the 4-bit counter datapath.
- Conditions raw board pushbuttons and switches: synchronizer, debouncer, press-edge detector.
- Produces the data bus, load and up/down direction controls the counter consumes.
- Load is stretched long enough to be sampled by a counter running on the divided (slow) clock.
- Sits between the board I/O pins and the counter instance, all in the fast board-clock domain.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable clk cycles required to accept a new button level (20 ms at 50 MHz).
- HOLD_CYCLES, 50_000_000, clk cycles load stays asserted after a capture (one 1 Hz slow-clock period at 50 MHz).
- BTN_ACTIVE_LOW, 1, 1 = raw buttons read 0 when pressed; 0 = read 1 when pressed.

Ports:
- clk  input  1  board clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- btn_load  input  1  raw load pushbutton, asynchronous.
- btn_dir  input  1  raw direction pushbutton, asynchronous.
- sw_data  input  4  raw data switches, asynchronous.
- data_out  output  4  captured load value, to counter data_in.
- load  output  1  stretched load enable, to counter load.
- up_down  output  1  count direction (1 = up, 0 = down), to counter up_down.

Behaviour:
- Reset (rst = 0, asynchronous): data_out = 0, load = 0, up_down = 1, all synchronizer flops and debounce counters cleared, debounced states = not pressed, load FSM = L_IDLE.
- Synchronization: every raw input passes through a 2-flop synchronizer. Buttons are normalized to logical "pressed = 1" per BTN_ACTIVE_LOW after synchronization.
- Debounce (one instance per button):
  - Keep a stable state and a counter.
  - Counter clears whenever the synced level equals the stable state.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, the stable state takes the synced level and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles produces no change.
  - Counter width = clog2(DEBOUNCE_CYCLES). Counter saturates only via the clear; no wrap.
- Press event: one-cycle internal pulse when a stable state goes 0 -> 1. Release generates no event.
- Press latency: 2 (sync) + DEBOUNCE_CYCLES cycles from the raw edge to the press event.
- Load FSM, states L_IDLE and L_HOLD:
  - L_IDLE + load press event: data_out <= synced sw_data, load <= 1, hold counter <= 0, go to L_HOLD. Both take effect on the cycle after the event.
  - L_HOLD: hold counter increments each cycle. When it reaches HOLD_CYCLES-1: load <= 0, go to L_IDLE. Load is high for exactly HOLD_CYCLES cycles.
  - Load press events during L_HOLD are ignored; data_out is not recaptured.
  - Switch changes never affect data_out except at capture.
- Direction: see Optional Feature. Direction changes are independent of load state and may occur during L_HOLD.
- Simultaneous load and dir press events in the same cycle: both are honoured.
- Reset mid-L_HOLD: load drops immediately (asynchronously) and the FSM returns to L_IDLE.

Optional Feature:
- Macro: COUNTER_INPUT_DIR_TOGGLE_EN.
- Defined: each btn_dir press event toggles up_down, one cycle after the event. Holding the button produces a single toggle.
- Undefined: up_down = NOT debounced btn_dir state. Released = 1 (up), held = 0 (down). Follows the debounced level with no extra latency beyond the debouncer.

Test Plan (DEBOUNCE_CYCLES = 4, HOLD_CYCLES = 8, BTN_ACTIVE_LOW = 1):
- Reset: rst = 0 mid-run -> data_out = 0, load = 0, up_down = 1 immediately. Release rst with btn_load = 1 held -> no load pulse.
- Clean load: sw_data = 4'hA, btn_load driven 0 and held -> load rises 2 + 4 + 1 cycles after the edge, stays high exactly 8 cycles, data_out = 4'hA. Changing sw_data to 4'h3 during the hold leaves data_out = 4'hA.
- Bounce rejection: btn_load toggled 0/1 every 2 cycles for 20 cycles, then held 1 -> load never asserts, data_out unchanged.
- Repeat press during hold: second clean press of btn_load while load = 1 -> load stays high exactly 8 cycles total, no recapture. A press after load falls -> new 8-cycle pulse capturing the current sw_data.
- Direction, macro defined: three separate debounced btn_dir presses -> up_down 1 -> 0 -> 1 -> 0. Holding btn_dir low for 40 cycles -> single toggle.
- Direction, macro undefined: btn_dir held 0 -> up_down = 0 after 6 cycles; released -> up_down = 1 after 6 cycles. A 2-cycle glitch -> no change.
